// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared synchronous memory port.
// One transfer in flight; data/exception returned with a one-cycle ack.
package mem_pkg;
  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef struct packed {
    logic load_fault;
    logic store_fault;
    logic misaligned;
  } mem_exception_mask_t;
endpackage

module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [31:0]         m0_addr,
  input  logic [31:0]         m0_wr_data,
  input  logic                m0_wr_ena,
  input  mem_access_t         m0_access,
  output logic                m0_ack,
  output logic [31:0]         m0_rd_data,
  output mem_exception_mask_t m0_exception,
  input  logic                m1_req,
  input  logic [31:0]         m1_addr,
  input  logic [31:0]         m1_wr_data,
  input  logic                m1_wr_ena,
  input  mem_access_t         m1_access,
  output logic                m1_ack,
  output logic [31:0]         m1_rd_data,
  output mem_exception_mask_t m1_exception,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [31:0]         mem_rd_data,
  input  mem_exception_mask_t mem_exception,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_t              state;
  state_t              state_nxt;
  logic                prio;
  logic [2:0]          cnt;
  logic                grant;
  logic                grant_id;
  logic                capture;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                wena_q;
  mem_access_t         access_q;
  logic [31:0]         rdata_q;
  mem_exception_mask_t exc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = owner;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          grant_id  = (m0_req && m1_req) ? prio : m1_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      cnt      <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wena_q   <= 1'b0;
      access_q <= MEM_ACCESS_WORD;
      rdata_q  <= '0;
      exc_q    <= '0;
    end else begin
      if (grant) begin
        owner    <= grant_id;
        addr_q   <= grant_id ? m1_addr : m0_addr;
        wdata_q  <= grant_id ? m1_wr_data : m0_wr_data;
        wena_q   <= grant_id ? m1_wr_ena : m0_wr_ena;
        access_q <= grant_id ? m1_access : m0_access;
      end
      if (state == ISSUE)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      if (capture) begin
        rdata_q <= mem_rd_data;
        exc_q   <= mem_exception;
      end
      if (state == RESP) prio <= ~owner;
    end
  end

  // Port driven only from registers, so req never reaches it combinationally.
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign mem_access  = access_q;
  assign mem_wr_ena  = (state == ISSUE) && wena_q;

  assign busy   = (state != IDLE);
  assign m0_ack = (state == RESP) && !owner;
  assign m1_ack = (state == RESP) && owner;

  assign m0_rd_data   = m0_ack ? rdata_q : '0;
  assign m1_rd_data   = m1_ack ? rdata_q : '0;
  assign m0_exception = m0_ack ? exc_q : '0;
  assign m1_exception = m1_ack ? exc_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: READ_LATENCY=2 (a_*) and
// READ_LATENCY=1 (b_*) instances driven cycle by cycle.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic                a_m0_req, a_m1_req, a_m0_we, a_m1_we;
  logic [31:0]         a_m0_addr, a_m1_addr, a_m0_wd, a_m1_wd;
  mem_access_t         a_m0_acc, a_m1_acc, a_mem_acc;
  logic                a_m0_ack, a_m1_ack, a_mem_we, a_busy, a_owner;
  logic [31:0]         a_m0_rd, a_m1_rd, a_mem_addr, a_mem_wd, a_mem_rd;
  mem_exception_mask_t a_m0_exc, a_m1_exc, a_mem_exc;

  logic                b_m0_req, b_m1_req, b_m0_we, b_m1_we;
  logic [31:0]         b_m0_addr, b_m1_addr, b_m0_wd, b_m1_wd;
  mem_access_t         b_m0_acc, b_m1_acc, b_mem_acc;
  logic                b_m0_ack, b_m1_ack, b_mem_we, b_busy, b_owner;
  logic [31:0]         b_m0_rd, b_m1_rd, b_mem_addr, b_mem_wd, b_mem_rd;
  mem_exception_mask_t b_m0_exc, b_m1_exc, b_mem_exc;

  mem_port_arbiter #(.READ_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wr_data(a_m0_wd),
    .m0_wr_ena(a_m0_we), .m0_access(a_m0_acc), .m0_ack(a_m0_ack),
    .m0_rd_data(a_m0_rd), .m0_exception(a_m0_exc),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wr_data(a_m1_wd),
    .m1_wr_ena(a_m1_we), .m1_access(a_m1_acc), .m1_ack(a_m1_ack),
    .m1_rd_data(a_m1_rd), .m1_exception(a_m1_exc),
    .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wd), .mem_wr_ena(a_mem_we),
    .mem_access(a_mem_acc), .mem_rd_data(a_mem_rd),
    .mem_exception(a_mem_exc), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.READ_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wr_data(b_m0_wd),
    .m0_wr_ena(b_m0_we), .m0_access(b_m0_acc), .m0_ack(b_m0_ack),
    .m0_rd_data(b_m0_rd), .m0_exception(b_m0_exc),
    .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wr_data(b_m1_wd),
    .m1_wr_ena(b_m1_we), .m1_access(b_m1_acc), .m1_ack(b_m1_ack),
    .m1_rd_data(b_m1_rd), .m1_exception(b_m1_exc),
    .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wd), .mem_wr_ena(b_mem_we),
    .mem_access(b_mem_acc), .mem_rd_data(b_mem_rd),
    .mem_exception(b_mem_exc), .busy(b_busy), .owner(b_owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++;
    if ({a_busy, a_owner, a_m0_ack, a_m1_ack, a_mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_a_ctl: got %b want 00000",
               {a_busy, a_owner, a_m0_ack, a_m1_ack, a_mem_we});
    end
    n_vec++;
    if ({a_mem_addr, a_mem_wd, a_m0_rd, a_m1_rd} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_a_data: got %h want 0",
               {a_mem_addr, a_mem_wd, a_m0_rd, a_m1_rd});
    end
    n_vec++;
    if ({a_m0_exc, a_m1_exc} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_a_exc: got %b want 0", {a_m0_exc, a_m1_exc});
    end
    n_vec++;
    if (a_mem_acc !== MEM_ACCESS_WORD) begin
      n_err++;
      $display("FAIL reset_a_access: got %0d want %0d",
               a_mem_acc, MEM_ACCESS_WORD);
    end
    n_vec++;
    if ({b_busy, b_owner, b_m0_ack, b_m1_ack, b_mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_b_ctl: got %b want 00000",
               {b_busy, b_owner, b_m0_ack, b_m1_ack, b_mem_we});
    end
    rst = 1'b0;
  endtask

  task automatic test_read;
    logic exp_ack;
    a_m0_addr = 32'h10;
    a_m0_we   = 1'b0;
    a_m0_req  = 1'b1;
    a_mem_rd  = 32'h0BAD_0000;
    for (int c = 1; c <= 5; c++) begin
      tick;
      a_mem_rd = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + c;
      if (c == 2) a_m0_addr = 32'hFFFF_FFF0;
      if (c == 1 || c == 2) begin
        n_vec++;
        if (a_mem_addr !== 32'h10 || a_owner !== 1'b0) begin
          n_err++;
          $display("FAIL read_addr c%0d: got %h/%b want 10/0",
                   c, a_mem_addr, a_owner);
        end
      end
      exp_ack = (c == 4);
      n_vec++;
      if (a_m0_ack !== exp_ack || a_m1_ack !== 1'b0) begin
        n_err++;
        $display("FAIL read_ack c%0d: got %b%b want %b0",
                 c, a_m0_ack, a_m1_ack, exp_ack);
      end
      if (c == 4) begin
        n_vec++;
        if (a_m0_rd !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL read_data: got %h want deadbeef", a_m0_rd);
        end
        a_m0_req = 1'b0;
      end
      if (c == 5) begin
        n_vec++;
        if (a_busy !== 1'b0) begin
          n_err++;
          $display("FAIL read_idle: got busy %b want 0", a_busy);
        end
      end
    end
  endtask

  task automatic test_write;
    logic exp_we;
    logic exp_ack;
    a_m1_addr = 32'h40;
    a_m1_wd   = 32'h1234_5678;
    a_m1_we   = 1'b1;
    a_m1_req  = 1'b1;
    a_mem_exc = '0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      exp_we = (c == 1);
      n_vec++;
      if (a_mem_we !== exp_we) begin
        n_err++;
        $display("FAIL write_strobe c%0d: got %b want %b",
                 c, a_mem_we, exp_we);
      end
      if (c == 1) begin
        n_vec++;
        if (a_mem_wd !== 32'h1234_5678 || a_mem_addr !== 32'h40
            || a_owner !== 1'b1) begin
          n_err++;
          $display("FAIL write_port: got %h@%h o%b want 12345678@40 o1",
                   a_mem_wd, a_mem_addr, a_owner);
        end
      end
      exp_ack = (c == 4);
      n_vec++;
      if (a_m1_ack !== exp_ack || a_m0_ack !== 1'b0) begin
        n_err++;
        $display("FAIL write_ack c%0d: got m1 %b m0 %b want %b 0",
                 c, a_m1_ack, a_m0_ack, exp_ack);
      end
      if (c == 4) a_m1_req = 1'b0;
    end
    a_m1_we = 1'b0;
  endtask

  task automatic test_back_to_back;
    int k;
    int c;
    int exp_c;
    logic exp_m;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a_m0_addr = 32'h100;
    a_m1_addr = 32'h200;
    a_m0_req  = 1'b1;
    a_m1_req  = 1'b1;
    k = 0;
    c = 0;
    while (k < 4 && c < 30) begin
      tick;
      c++;
      n_vec++;
      if (a_m0_ack && a_m1_ack) begin
        n_err++;
        $display("FAIL rr_overlap c%0d: got both acks want one", c);
      end
      if (a_m0_ack || a_m1_ack) begin
        exp_c = 4 + 5 * k;
        exp_m = k[0];
        n_vec++;
        if (a_m1_ack !== exp_m || c != exp_c) begin
          n_err++;
          $display("FAIL rr_order k%0d: got m%0d@%0d want m%0d@%0d",
                   k, a_m1_ack, c, exp_m, exp_c);
        end
        k++;
      end
    end
    n_vec++;
    if (k != 4) begin
      n_err++;
      $display("FAIL rr_count: got %0d acks want 4", k);
    end
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    tick;
  endtask

  task automatic test_exception;
    mem_exception_mask_t mis;
    mis = '0;
    mis.misaligned = 1'b1;
    for (int t = 0; t < 2; t++) begin
      a_m0_addr = (t == 0) ? 32'h13 : 32'h14;
      a_m0_req  = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        tick;
        if (t == 0) a_mem_exc = (c == 3) ? mis : '0;
        else        a_mem_exc = (c == 3) ? '0 : mis;
        if (c == 4) begin
          n_vec++;
          if (a_m0_ack !== 1'b1 || a_m0_exc !== ((t == 0) ? mis : '0)) begin
            n_err++;
            $display("FAIL exc_mask t%0d: got ack %b exc %b want 1 %b",
                     t, a_m0_ack, a_m0_exc, (t == 0) ? mis : '0);
          end
          n_vec++;
          if (a_m1_exc !== '0) begin
            n_err++;
            $display("FAIL exc_other t%0d: got %b want 000", t, a_m1_exc);
          end
          a_m0_req = 1'b0;
        end
      end
    end
    a_mem_exc = '0;
  endtask

  task automatic test_reset_abort;
    a_m1_addr = 32'h300;
    a_m1_req  = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_vec++;
    if ({a_busy, a_m1_ack, a_mem_we, a_owner} !== 4'b0) begin
      n_err++;
      $display("FAIL abort_state: got %b want 0000",
               {a_busy, a_m1_ack, a_mem_we, a_owner});
    end
    a_m0_addr = 32'h400;
    a_m0_req  = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      tick;
      n_vec++;
      if (a_m1_ack !== 1'b0 || a_mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL abort_m1 c%0d: got ack %b we %b want 0 0",
                 c, a_m1_ack, a_mem_we);
      end
      if (c == 4) begin
        n_vec++;
        if (a_owner !== 1'b0 || a_mem_addr !== 32'h400) begin
          n_err++;
          $display("FAIL abort_grant: got o%b %h want o0 400",
                   a_owner, a_mem_addr);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (a_m0_ack !== 1'b1) begin
          n_err++;
          $display("FAIL abort_m0ack: got %b want 1", a_m0_ack);
        end
        a_m0_req = 1'b0;
        a_m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency1;
    logic exp_ack;
    b_m0_addr = 32'h80;
    b_m0_req  = 1'b1;
    b_mem_rd  = 32'h0BAD_1000;
    for (int c = 1; c <= 6; c++) begin
      tick;
      b_mem_rd = (c == 2) ? 32'hA5A5_0001 : 32'h0BAD_1000 + c;
      if (c == 2) b_m1_req = 1'b1;
      if (c == 3) b_m1_req = 1'b0;
      if (c == 1) begin
        n_vec++;
        if (b_mem_addr !== 32'h80) begin
          n_err++;
          $display("FAIL l1_addr: got %h want 80", b_mem_addr);
        end
      end
      exp_ack = (c == 3);
      n_vec++;
      if (b_m0_ack !== exp_ack || b_m1_ack !== 1'b0
          || b_owner !== 1'b0) begin
        n_err++;
        $display("FAIL l1_ack c%0d: got %b%b o%b want %b0 o0",
                 c, b_m0_ack, b_m1_ack, b_owner, exp_ack);
      end
      if (c == 3) begin
        n_vec++;
        if (b_m0_rd !== 32'hA5A5_0001) begin
          n_err++;
          $display("FAIL l1_data: got %h want a5a50001", b_m0_rd);
        end
        b_m0_req = 1'b0;
      end
      if (c >= 4) begin
        n_vec++;
        if (b_busy !== 1'b0) begin
          n_err++;
          $display("FAIL l1_idle c%0d: got busy %b want 0", c, b_busy);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {a_m0_req, a_m1_req, a_m0_we, a_m1_we} = '0;
    {a_m0_addr, a_m1_addr, a_m0_wd, a_m1_wd, a_mem_rd} = '0;
    {b_m0_req, b_m1_req, b_m0_we, b_m1_we} = '0;
    {b_m0_addr, b_m1_addr, b_m0_wd, b_m1_wd, b_mem_rd} = '0;
    a_m0_acc = MEM_ACCESS_WORD;
    a_m1_acc = MEM_ACCESS_WORD;
    b_m0_acc = MEM_ACCESS_WORD;
    b_m1_acc = MEM_ACCESS_WORD;
    a_mem_exc = '0;
    b_mem_exc = '0;
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_exception;
    test_reset_abort;
    test_latency1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
